// File: rtl/page_fault_tracker_pkg.sv
// rtl/page_fault_tracker_pkg.sv - ExceptStruct package: exception pack, fault slot types, ecause codes
package ExceptStruct;

   localparam int XLEN = 64;

   // Trap cause codes for the three page-fault flavours
   localparam logic [XLEN-1:0] INST_PAGE_FAULT  = XLEN'(12);
   localparam logic [XLEN-1:0] LOAD_PAGE_FAULT  = XLEN'(13);
   localparam logic [XLEN-1:0] STORE_PAGE_FAULT = XLEN'(15);

   typedef struct packed {
      logic            except;
      logic [XLEN-1:0] epc;
      logic [XLEN-1:0] ecause;
      logic [XLEN-1:0] etval;
   } ExceptPack;

   typedef enum logic [1:0] {
      PF_NONE  = 2'b00,
      PF_INST  = 2'b01,
      PF_LOAD  = 2'b10,
      PF_STORE = 2'b11
   } pf_type_e;

   // A slot is occupied whenever its type is not PF_NONE
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] va;
      pf_type_e        ptype;
   } pf_slot_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PRESENT = 2'b01,
      ST_CLEAR   = 2'b10
   } pf_state_e;

   function automatic logic [XLEN-1:0] ecause_of(input pf_type_e t);
      case (t)
         PF_INST:  return INST_PAGE_FAULT;
         PF_LOAD:  return LOAD_PAGE_FAULT;
         PF_STORE: return STORE_PAGE_FAULT;
         default:  return '0;
      endcase
   endfunction

endpackage

// File: rtl/page_fault_tracker_prio_select.sv
// rtl/page_fault_tracker_prio_select.sv - pf_prio_select: highest-index occupied slot picker
import ExceptStruct::*;

module pf_prio_select #(
   parameter int NCH = 3
) (
   input  pf_slot_t [NCH-1:0] slot_i,
   input  logic     [NCH-1:0] valid_i,
   output logic     [NCH-1:0] grant_o,
   output pf_slot_t           sel_o
);

   // Ascending scan so the highest occupied index (oldest stage) wins
   always_comb begin
      grant_o = '0;
      sel_o   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (valid_i[k]) begin
            grant_o    = '0;
            grant_o[k] = 1'b1;
            sel_o      = slot_i[k];
         end
      end
   end

endmodule

// File: rtl/page_fault_tracker.sv
// rtl/page_fault_tracker.sv - multi-channel page-fault collector and presenter; PF_STATS_EN adds per-type ack counters
import ExceptStruct::*;

module page_fault_tracker #(
   parameter int NCH    = 3,
   parameter int XLEN   = ExceptStruct::XLEN,
   parameter int DROP_W = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NCH-1:0]            pf_valid_i,
   input  logic [NCH-1:0][1:0]       pf_type_i,
   input  logic [NCH-1:0][XLEN-1:0]  pf_pc_i,
   input  logic [NCH-1:0][XLEN-1:0]  pf_va_i,
   input  logic                      flush_i,
   input  logic                      ack_i,
   output ExceptPack                 except_o,
   output logic [NCH-1:0]            pending_o,
   output logic                      busy_o,
   output logic [DROP_W-1:0]         drop_cnt_o,
   output logic [15:0]               stat_inst_o,
   output logic [15:0]               stat_load_o,
   output logic [15:0]               stat_store_o
);

   pf_slot_t [NCH-1:0] slot_q, slot_d;
   pf_state_e          state_q, state_d;
   ExceptPack          except_q, except_d;
   logic [DROP_W-1:0]  drop_q, drop_d;

   logic [NCH-1:0] occ_q, occ_d, rpt, cap, drop, grant;
   logic           ack_take, cap_en, clear_all;
   pf_slot_t       sel_slot;

   // Capture/drop qualification; trap hand-off and flush both discard new reports
   always_comb begin
      ack_take  = ack_i && (state_q == ST_PRESENT);
      clear_all = flush_i || ack_take || (state_q == ST_CLEAR);
      cap_en    = !clear_all;
      for (int k = 0; k < NCH; k++) begin
         rpt[k]   = pf_valid_i[k] && (pf_type_i[k] != 2'b00);
         occ_q[k] = (slot_q[k].ptype != PF_NONE);
         cap[k]   = cap_en && rpt[k] && !occ_q[k];
         drop[k]  = cap_en && rpt[k] && occ_q[k];
      end
   end

   // Next slot contents; selection looks at these so a report shows up one cycle later
   always_comb begin
      slot_d = slot_q;
      if (clear_all) begin
         slot_d = '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (cap[k]) begin
               slot_d[k].pc    = pf_pc_i[k];
               slot_d[k].va    = pf_va_i[k];
               slot_d[k].ptype = pf_type_e'(pf_type_i[k]);
            end
         end
      end
      for (int k = 0; k < NCH; k++) begin
         occ_d[k] = (slot_d[k].ptype != PF_NONE);
      end
   end

   pf_prio_select #(.NCH(NCH)) u_prio (
      .slot_i  (slot_d),
      .valid_i (occ_d),
      .grant_o (grant),
      .sel_o   (sel_slot)
   );

   // FSM next state and the registered exception pack
   always_comb begin
      state_d  = state_q;
      except_d = '0;
      unique case (state_q)
         ST_IDLE:    if (|occ_d) state_d = ST_PRESENT;
         ST_PRESENT: begin
            if (ack_take)     state_d = ST_CLEAR;
            else if (flush_i) state_d = ST_IDLE;
         end
         ST_CLEAR:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (state_d == ST_PRESENT && |grant) begin
         except_d.except = 1'b1;
         except_d.epc    = sel_slot.pc;
         except_d.ecause = ecause_of(sel_slot.ptype);
         except_d.etval  = sel_slot.va;
      end
   end

   // Saturating drop counter; several channels may drop in one cycle
   always_comb begin
      drop_d = drop_q;
      for (int k = 0; k < NCH; k++) begin
         if (drop[k] && drop_d != '1) drop_d = drop_d + DROP_W'(1);
      end
   end

   // Main state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_q   <= '0;
         state_q  <= ST_IDLE;
         except_q <= '0;
         drop_q   <= '0;
      end else begin
         slot_q   <= slot_d;
         state_q  <= state_d;
         except_q <= except_d;
         drop_q   <= drop_d;
      end
   end

   assign except_o   = except_q;
   assign pending_o  = occ_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign drop_cnt_o = drop_q;

`ifdef PF_STATS_EN
   logic [15:0] stat_inst_q, stat_inst_d;
   logic [15:0] stat_load_q, stat_load_d;
   logic [15:0] stat_store_q, stat_store_d;

   // Count acknowledged faults by the cause currently presented
   always_comb begin
      stat_inst_d  = stat_inst_q;
      stat_load_d  = stat_load_q;
      stat_store_d = stat_store_q;
      if (ack_take) begin
         if (except_q.ecause == INST_PAGE_FAULT && stat_inst_q != '1)
            stat_inst_d = stat_inst_q + 16'd1;
         if (except_q.ecause == LOAD_PAGE_FAULT && stat_load_q != '1)
            stat_load_d = stat_load_q + 16'd1;
         if (except_q.ecause == STORE_PAGE_FAULT && stat_store_q != '1)
            stat_store_d = stat_store_q + 16'd1;
      end
   end

   // Statistics registers, cleared only by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_inst_q  <= '0;
         stat_load_q  <= '0;
         stat_store_q <= '0;
      end else begin
         stat_inst_q  <= stat_inst_d;
         stat_load_q  <= stat_load_d;
         stat_store_q <= stat_store_d;
      end
   end

   assign stat_inst_o  = stat_inst_q;
   assign stat_load_o  = stat_load_q;
   assign stat_store_o = stat_store_q;
`else
   assign stat_inst_o  = '0;
   assign stat_load_o  = '0;
   assign stat_store_o = '0;
`endif

endmodule

// File: tb/tb_page_fault_tracker.sv
// tb/tb_page_fault_tracker.sv - scoreboard bench for page_fault_tracker
import ExceptStruct::*;

module tb_page_fault_tracker;

   localparam int NCH    = 3;
   localparam int XLEN   = 64;
   localparam int DROP_W = 8;
`ifdef PF_STATS_EN
   localparam logic [15:0] STAT1 = 16'd1;
`else
   localparam logic [15:0] STAT1 = 16'd0;
`endif

   logic                     clk = 1'b0;
   logic                     rstn;
   logic [NCH-1:0]           pf_valid_i;
   logic [NCH-1:0][1:0]      pf_type_i;
   logic [NCH-1:0][XLEN-1:0] pf_pc_i;
   logic [NCH-1:0][XLEN-1:0] pf_va_i;
   logic                     flush_i;
   logic                     ack_i;
   ExceptPack                except_o;
   logic [NCH-1:0]           pending_o;
   logic                     busy_o;
   logic [DROP_W-1:0]        drop_cnt_o;
   logic [15:0]              stat_inst_o, stat_load_o, stat_store_o;

   int checks = 0;
   int errors = 0;
   ExceptPack exp_q[$];
   ExceptPack prev_pack;
   ExceptPack exp_pack;

   page_fault_tracker #(.NCH(NCH), .XLEN(XLEN), .DROP_W(DROP_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .pf_valid_i   (pf_valid_i),
      .pf_type_i    (pf_type_i),
      .pf_pc_i      (pf_pc_i),
      .pf_va_i      (pf_va_i),
      .flush_i      (flush_i),
      .ack_i        (ack_i),
      .except_o     (except_o),
      .pending_o    (pending_o),
      .busy_o       (busy_o),
      .drop_cnt_o   (drop_cnt_o),
      .stat_inst_o  (stat_inst_o),
      .stat_load_o  (stat_load_o),
      .stat_store_o (stat_store_o)
   );

   always #5 clk = ~clk;

   function automatic ExceptPack mk(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] va);
      ExceptPack p;
      p.except = 1'b1;
      p.epc    = pc;
      p.ecause = cause;
      p.etval  = va;
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      pf_valid_i = '0;
      pf_type_i  = '0;
      pf_pc_i    = '0;
      pf_va_i    = '0;
   endtask

   task automatic rpt(input int ch, input logic [1:0] t, input logic [63:0] pc, input logic [63:0] va);
      pf_valid_i[ch] = 1'b1;
      pf_type_i[ch]  = t;
      pf_pc_i[ch]    = pc;
      pf_va_i[ch]    = va;
   endtask

   // Monitor: each new presentation of an exception consumes one expected pack
   always @(negedge clk) begin
      if (!rstn) begin
         prev_pack = '0;
      end else begin
         if (except_o.except && except_o != prev_pack) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL present_unexpected: got ecause=%0d epc=%h etval=%h, required no new exception",
                        except_o.ecause, except_o.epc, except_o.etval);
            end else begin
               exp_pack = exp_q.pop_front();
               if (except_o != exp_pack) begin
                  errors++;
                  $display("FAIL present: got ecause=%0d epc=%h etval=%h, required ecause=%0d epc=%h etval=%h",
                           except_o.ecause, except_o.epc, except_o.etval,
                           exp_pack.ecause, exp_pack.epc, exp_pack.etval);
               end
            end
         end
         prev_pack = except_o;
      end
   end

   initial begin
      rstn = 1'b0;
      clr_in();
      ack_i   = 1'b0;
      flush_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_except",  {63'd0, except_o != '0}, 64'd0);
      chk("reset_pending", 64'(pending_o), 64'd0);
      chk("reset_busy",    64'(busy_o), 64'd0);
      chk("reset_drop",    64'(drop_cnt_o), 64'd0);
      chk("reset_stats",   {16'd0, stat_inst_o, stat_load_o, stat_store_o}, 64'd0);
      rstn = 1'b1;
      tick();

      // single instruction fault on ch0
      exp_q.push_back(mk(64'd12, 64'h8000_0010, 64'h8000_0010));
      rpt(0, 2'b01, 64'h8000_0010, 64'h8000_0010);
      tick();
      clr_in();
      chk("single_latency", 64'(except_o.except), 64'd1);
      chk("single_ecause",  except_o.ecause, 64'd12);
      chk("single_pending", 64'(pending_o), 64'b001);
      chk("single_busy",    64'(busy_o), 64'd1);
      tick();
      tick();
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      chk("single_clear_except",  64'(except_o.except), 64'd0);
      chk("single_clear_epc",     except_o.epc, 64'd0);
      chk("single_clear_pending", 64'(pending_o), 64'd0);
      chk("single_clear_busy",    64'(busy_o), 64'd1);
      tick();
      chk("single_idle_busy", 64'(busy_o), 64'd0);

      // preemption: ch2 store replaces ch0 instruction fault
      exp_q.push_back(mk(64'd12, 64'h100, 64'h104));
      exp_q.push_back(mk(64'd15, 64'h200, 64'h1000));
      rpt(0, 2'b01, 64'h100, 64'h104);
      tick();
      clr_in();
      tick();
      rpt(2, 2'b11, 64'h200, 64'h1000);
      tick();
      clr_in();
      chk("preempt_ecause",  except_o.ecause, 64'd15);
      chk("preempt_etval",   except_o.etval, 64'h1000);
      chk("preempt_pending", 64'(pending_o), 64'b101);
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      chk("preempt_ack_pending", 64'(pending_o), 64'd0);
      tick();
      chk("preempt_idle", 64'(busy_o), 64'd0);

      // ack outside PRESENT and type-00 reports are ignored
      ack_i = 1'b1;
      rpt(0, 2'b00, 64'h700, 64'h7000);
      tick();
      ack_i = 1'b0;
      clr_in();
      chk("ignore_busy",    64'(busy_o), 64'd0);
      chk("ignore_pending", 64'(pending_o), 64'd0);

      // drops on an occupied ch1 slot
      exp_q.push_back(mk(64'd13, 64'h300, 64'h3000));
      rpt(1, 2'b10, 64'h300, 64'h3000);
      tick();
      rpt(1, 2'b10, 64'h310, 64'h9999);
      repeat (3) tick();
      clr_in();
      chk("drop_count",   64'(drop_cnt_o), 64'd3);
      chk("drop_etval",   except_o.etval, 64'h3000);
      chk("drop_pending", 64'(pending_o), 64'b010);

      // flush with a same-cycle report
      flush_i = 1'b1;
      rpt(0, 2'b01, 64'h400, 64'h4000);
      tick();
      flush_i = 1'b0;
      clr_in();
      chk("flush_except",  64'(except_o.except), 64'd0);
      chk("flush_pending", 64'(pending_o), 64'd0);
      chk("flush_drop",    64'(drop_cnt_o), 64'd3);
      chk("flush_busy",    64'(busy_o), 64'd0);

      // drop counter saturation
      exp_q.push_back(mk(64'd13, 64'h500, 64'h5000));
      rpt(1, 2'b10, 64'h500, 64'h5000);
      tick();
      rpt(1, 2'b10, 64'h510, 64'h5555);
      repeat (300) tick();
      clr_in();
      chk("drop_saturate", 64'(drop_cnt_o), 64'd255);
      chk("drop_sat_etval", except_o.etval, 64'h5000);

      // ack and flush together on a load fault
      ack_i   = 1'b1;
      flush_i = 1'b1;
      tick();
      ack_i   = 1'b0;
      flush_i = 1'b0;
      chk("ackflush_except",  64'(except_o.except), 64'd0);
      chk("ackflush_pending", 64'(pending_o), 64'd0);
      tick();
      chk("ackflush_idle", 64'(busy_o), 64'd0);
      chk("stat_inst",  64'(stat_inst_o), 64'(STAT1));
      chk("stat_load",  64'(stat_load_o), 64'(STAT1));
      chk("stat_store", 64'(stat_store_o), 64'(STAT1));

      // simultaneous capture on all channels
      exp_q.push_back(mk(64'd15, 64'h600, 64'h6000));
      rpt(0, 2'b01, 64'h620, 64'h6200);
      rpt(1, 2'b10, 64'h610, 64'h6100);
      rpt(2, 2'b11, 64'h600, 64'h6000);
      tick();
      clr_in();
      chk("simul_pending", 64'(pending_o), 64'b111);
      chk("simul_ecause",  except_o.ecause, 64'd15);

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("async_except",  {63'd0, except_o != '0}, 64'd0);
      chk("async_pending", 64'(pending_o), 64'd0);
      #3;
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/page_fault_tracker.md
Name: page_fault_tracker

Overview:
- Parametrised multi-channel successor to the single-stage page-fault examiner.
- Collects page-fault reports from NCH pipeline/MMU channels (e.g. IF, MEM, PTW) into per-channel pending slots.
- Selects the oldest fault and presents it as one registered ExceptPack to the CSR/trap unit.
- Holds the fault until acknowledged or flushed; reports the faulting virtual address in etval, not the PC.

Parameters:
- NCH, 3: number of fault channels; channel NCH-1 is the oldest pipeline stage and has highest priority.
- XLEN, 64: width of PC, VA and ExceptPack fields.
- DROP_W, 8: width of the saturating dropped-fault counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- pf_valid_i  in  NCH  per-channel page-fault report strobe.
- pf_type_i  in  NCH x 2  00 none, 01 inst, 10 load, 11 store.
- pf_pc_i  in  NCH x XLEN  PC of the faulting instruction.
- pf_va_i  in  NCH x XLEN  faulting virtual address.
- flush_i  in  1  pipeline flush; discards all pending faults.
- ack_i  in  1  trap unit has taken the presented exception.
- except_o  out  ExceptStruct::ExceptPack  registered exception (except, epc, ecause, etval).
- pending_o  out  NCH  slot occupancy.
- busy_o  out  1  FSM not in IDLE.
- drop_cnt_o  out  DROP_W  saturating count of dropped reports.
- stat_inst_o, stat_load_o, stat_store_o  out  16 each  see Optional Feature.

Behaviour:
- Reset (rstn low, asynchronous): all slots empty, FSM IDLE, except_o all-zero, pending_o=0, busy_o=0, drop_cnt_o=0, stats=0.
- Capture:
  - Slot k loads {pc, va, type} at a clock edge when pf_valid_i[k] & pf_type_i[k]!=00 & slot k empty & !flush_i & FSM!=CLEAR.
  - pf_valid_i with type 00 is ignored.
  - A valid report to an occupied slot is dropped and increments drop_cnt_o, saturating at all-ones.
- Selection: highest-index occupied slot wins; combinational over slots, then registered into except_o.
- Latency: report in cycle N -> except_o.except=1 in cycle N+1.
- FSM:
  - IDLE: any slot occupied -> PRESENT.
  - PRESENT: except_o driven from the winning slot, re-evaluated every cycle.
    - A newly captured higher-priority fault replaces the presented one in the next cycle (preemption; older instruction wins).
    - ack_i -> CLEAR.
  - CLEAR: one cycle. All slots emptied, except_o zeroed, captures blocked (the trap flushes the pipeline) -> IDLE.
- Encoding:
  - ecause: inst=12 (INST_PAGE_FAULT), load=13 (LOAD_PAGE_FAULT), store=15 (STORE_PAGE_FAULT), zero-extended to XLEN.
  - epc = slot pc; etval = slot va.
  - When except=0, epc, ecause and etval are all 0.
- flush_i in any state: all slots cleared, FSM -> IDLE, except_o zero next cycle. Reports in the flush cycle are discarded and not counted as drops.
- ack_i and flush_i together: treated as ack (stats count it); end state is the same, all clear then IDLE.
- ack_i outside PRESENT is ignored.
- Simultaneous reports on several channels are all captured in the same cycle.

Optional Feature:
- Macro PF_STATS_EN.
- Defined: stat_inst_o, stat_load_o, stat_store_o are 16-bit saturating counters incremented on each acknowledged fault of that type (ack_i in PRESENT, keyed on the presented type). Cleared only by reset.
- Undefined: ports exist, tied to 0, no counter flops.

Decomposition:
- ExceptStruct package: ExceptPack (existing), a pf_type_e enum (NONE, INST, LOAD, STORE), a pf_slot_t struct {pc, va, type}, and the ecause constants (from Define.vh macros).
- Natural sub-module: pf_prio_select, a parametrised highest-index-occupied picker returning a one-hot grant and the selected pf_slot_t.

Test Plan:
- Single fault: ch0 type 01, pc=0x8000_0010, va=0x8000_0010, cycle 5 -> cycle 6 except=1, ecause=12, epc=0x8000_0010, etval=0x8000_0010; ack cycle 8 -> CLEAR cycle 9, except=0 cycle 9.
- Preemption: ch0 inst fault in cycle 1, ch2 store fault va=0x1000 in cycle 3 -> except_o switches to ecause=15, etval=0x1000 in cycle 4; ack clears both slots.
- Drop: ch1 load fault held, three more ch1 reports -> drop_cnt_o=3, presented etval unchanged; 300 drops with DROP_W=8 -> saturates at 255.
- Flush: fault pending, flush_i with ch0 report in the same cycle -> next cycle except=0, pending_o=0, drop_cnt_o unchanged, busy_o=0.
- Ack+flush together in PRESENT with load fault -> all clear; with PF_STATS_EN stat_load_o=1, without it 0.
- Async reset asserted mid-PRESENT (between edges) -> except_o and pending_o zero immediately, before the next clk edge.
